// File: rtl/alu_seq.sv
// Handshaked sequential ALU: one operation in flight, registered result and flags.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier for opcode 11.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t state;

  logic [WIDTH-1:0] res_y;
  logic             res_c;
  logic             res_v;
  logic             res_e;
  logic [WIDTH:0]   wide;
  logic [SHW-1:0]   sh;

  assign sh = b[SHW-1:0];

  // The extra bit of 'wide' holds the carry-out for add/sub and the last bit shifted out for shifts.
  always_comb begin
    res_y = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    res_e = 1'b0;
    wide  = '0;
    case (op)
      4'd0: begin
        wide  = {1'b0, a} + {1'b0, b};
        res_y = wide[WIDTH-1:0];
        res_c = wide[WIDTH];
        res_v = (a[WIDTH-1] == b[WIDTH-1]) && (res_y[WIDTH-1] != a[WIDTH-1]);
      end
      4'd1: begin
        wide  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        res_y = wide[WIDTH-1:0];
        res_c = wide[WIDTH];
        res_v = (a[WIDTH-1] != b[WIDTH-1]) && (res_y[WIDTH-1] != a[WIDTH-1]);
      end
      4'd2: res_y = ~a;
      4'd3: res_y = a & b;
      4'd4: res_y = a | b;
      4'd5: res_y = a ^ b;
      4'd6: res_y = {{(WIDTH-1){1'b0}}, ($signed(a) > $signed(b))};
      4'd7: res_y = {{(WIDTH-1){1'b0}}, (a == b)};
      4'd8: begin
        wide  = {1'b0, a} << sh;
        res_y = wide[WIDTH-1:0];
        res_c = wide[WIDTH];
      end
      4'd9: begin
        wide  = {a, 1'b0} >> sh;
        res_y = wide[WIDTH:1];
        res_c = wide[0];
      end
      4'd10: begin
        wide  = $signed({a, 1'b0}) >>> sh;
        res_y = wide[WIDTH:1];
        res_c = wide[0];
      end
      default: res_e = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH-1:0]   mplier;
  logic [SHW-1:0]     count;
  logic               last;

  assign prod_next = prod + (mplier[0] ? mcand : '0);
  assign last      = (count == SHW'(WIDTH - 1));
`endif

  // Single FSM: IDLE accepts, MUL iterates one multiplier bit per cycle, DONE holds until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y         <= '0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      err       <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mcand     <= '0;
      prod      <= '0;
      mplier    <= '0;
      count     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            if (op == 4'd11) begin
              mcand  <= {{WIDTH{1'b0}}, a};
              mplier <= b;
              prod   <= '0;
              count  <= '0;
              state  <= MUL;
            end else
`endif
            begin
              y         <= res_y;
              carry     <= res_c;
              ovf       <= res_v;
              err       <= res_e;
              zero      <= (res_y == '0);
              neg       <= res_y[WIDTH-1];
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
`ifdef ALU_SEQ_MUL_EN
        MUL: begin
          prod   <= prod_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (last) begin
            y         <= prod_next[WIDTH-1:0];
            carry     <= |prod_next[2*WIDTH-1:WIDTH];
            ovf       <= 1'b0;
            err       <= 1'b0;
            zero      <= (prod_next[WIDTH-1:0] == '0);
            neg       <= prod_next[WIDTH-1];
            out_valid <= 1'b1;
            count     <= '0;
            state     <= DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at WIDTH=8; opcode 11 expectations follow ALU_SEQ_MUL_EN.
module tb_alu_seq;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             carry;
  logic             ovf;
  logic             zero;
  logic             neg;
  logic             err;

  int total = 0;
  int bad   = 0;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .carry(carry), .ovf(ovf), .zero(zero), .neg(neg), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] flagVec();
    return {carry, ovf, zero, neg, err};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one operation, waits for acceptance and reports the result latency (-1 on timeout).
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic [3:0] opv,
                               output int lat);
    int  cyc;
    bit  seen;
    @(negedge clk);
    checkOutput("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    a = av; b = bv; op = opv; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        cyc++;
      end
    end
    lat = seen ? cyc + 1 : -1;
  endtask

  task automatic consumeResult(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_in_ready_after_take"}, {31'd0, in_ready}, 32'd1);
    checkOutput({tag, "_out_valid_after_take"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic runVector(input string tag, input logic [7:0] av, input logic [7:0] bv,
                           input logic [3:0] opv, input logic [7:0] ey, input logic [4:0] ef,
                           input int elat);
    int lat;
    applyStimulus(av, bv, opv, lat);
    checkOutput({tag, "_latency"}, lat, elat);
    checkOutput({tag, "_y"}, {24'd0, y}, {24'd0, ey});
    checkOutput({tag, "_flags_cvznE"}, {27'd0, flagVec()}, {27'd0, ef});
    consumeResult(tag);
  endtask

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_y", {24'd0, y}, 32'd0);
    checkOutput("reset_flags", {27'd0, flagVec()}, 32'd0);

    // flags order: carry, ovf, zero, neg, err
    runVector("add_ovf",   8'h7F, 8'h01, 4'd0,  8'h80, 5'b01010, 1);
    runVector("add_carry", 8'hFF, 8'h01, 4'd0,  8'h00, 5'b10100, 1);
    runVector("sub_eq",    8'h05, 8'h05, 4'd1,  8'h00, 5'b10100, 1);
    runVector("sgt_neg",   8'hFF, 8'h01, 4'd6,  8'h00, 5'b00100, 1);
    runVector("sra",       8'h90, 8'h03, 4'd10, 8'hF2, 5'b00010, 1);
    runVector("sll",       8'h81, 8'h01, 4'd8,  8'h02, 5'b10000, 1);
    runVector("srl_zero",  8'hA5, 8'h00, 4'd9,  8'hA5, 5'b00010, 1);
    runVector("xor",       8'hF0, 8'h3C, 4'd5,  8'hCC, 5'b00010, 1);
    runVector("eq",        8'h42, 8'h42, 4'd7,  8'h01, 5'b00000, 1);
    runVector("not",       8'h0F, 8'h00, 4'd2,  8'hF0, 5'b00010, 1);
    runVector("illegal",   8'h12, 8'h34, 4'd13, 8'h00, 5'b00101, 1);
`ifdef ALU_SEQ_MUL_EN
    runVector("mul",       8'h10, 8'h11, 4'd11, 8'h10, 5'b10000, 9);
`else
    runVector("mul_off",   8'h10, 8'h11, 4'd11, 8'h00, 5'b00101, 1);
`endif

    // Back-pressure: result must hold and new requests must be ignored while not taken.
    applyStimulus(8'h10, 8'h20, 4'd0, lat);
    checkOutput("bp_latency", lat, 1);
    a = 8'hAA; b = 8'h55; op = 4'd4; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("bp_y", {24'd0, y}, 32'h30);
      checkOutput("bp_flags", {27'd0, flagVec()}, 32'd0);
    end
    in_valid = 1'b0;
    consumeResult("bp");
    checkOutput("bp_y_held_idle", {24'd0, y}, 32'h30);

    // Reset four cycles after issuing opcode 11 (mid-multiply when the multiplier is built).
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; op = 4'd11; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_mid_y", {24'd0, y}, 32'd0);
    checkOutput("rst_mid_flags", {27'd0, flagVec()}, 32'd0);
    runVector("add_after_rst", 8'h03, 8'h04, 4'd0, 8'h07, 5'b00000, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
